catalina_emu: RTL and testbench

CATALINA_EMU -- requirements
Module: catalina_emu

---
 rtl/catalina_pkg.sv | 33 +++
 rtl/catalina_deframer.sv | 99 +++++++++
 rtl/catalina_emu.sv | 112 +++++++++++
 tb/tb_catalina_emu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/catalina_pkg.sv
// Shared constants for the Catalina AD9361 bus emulator: phase encodings,
// per-mode frame patterns and deframer states.
package catalina_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        PH_I0 = 2'd0,
        PH_Q0 = 2'd1,
        PH_I1 = 2'd2,
        PH_Q1 = 2'd3
    } phase_e;

    // Bit n is the frame level carried by the word in phase n.
    localparam logic [3:0] FRAME_PAT_SISO = 4'b0001;
    localparam logic [3:0] FRAME_PAT_MIMO = 4'b0011;

    typedef enum logic {
        DF_HUNT   = 1'b0,
        DF_LOCKED = 1'b1
    } dfr_state_e;

    function automatic logic frame_bit(input logic mimo, input phase_e ph);
        logic [3:0] pat;
        pat = mimo ? FRAME_PAT_MIMO : FRAME_PAT_SISO;
        return pat[ph];
    endfunction

    function automatic phase_e last_phase(input logic mimo);
        return mimo ? PH_Q1 : PH_Q0;
    endfunction

endpackage

// File: rtl/catalina_deframer.sv
// Receive side: aligns on the frame edge of the FPGA TX port, checks the
// frame pattern every word and rebuilds complete I/Q sample sets.
module catalina_deframer
    import catalina_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode_i,
    input  logic             tx_frame_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic [WIDTH-1:0] snk_i0_o,
    output logic [WIDTH-1:0] snk_q0_o,
    output logic [WIDTH-1:0] snk_i1_o,
    output logic [WIDTH-1:0] snk_q1_o,
    output logic             snk_valid_o,
    output logic             locked_o,
    output logic [CNT_W-1:0] frame_err_cnt_o
);

    dfr_state_e       state_q;
    phase_e           rphase_q;
    logic             prev_frame_q;
    logic             mode_seen_q;
    logic [WIDTH-1:0] cap_i0_q, cap_q0_q, cap_i1_q;
    logic [WIDTH-1:0] snk_i0_q, snk_q0_q, snk_i1_q, snk_q1_q;
    logic             valid_q;
    logic [CNT_W-1:0] err_q;

    logic exp_frame;
    logic final_word;

    assign exp_frame  = frame_bit(mode_i, rphase_q);
    assign final_word = (rphase_q == last_phase(mode_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DF_HUNT;
            rphase_q     <= PH_I0;
            prev_frame_q <= 1'b1;
            mode_seen_q  <= 1'b0;
            cap_i0_q     <= '0;
            cap_q0_q     <= '0;
            cap_i1_q     <= '0;
            snk_i0_q     <= '0;
            snk_q0_q     <= '0;
            snk_i1_q     <= '0;
            snk_q1_q     <= '0;
            valid_q      <= 1'b0;
            err_q        <= '0;
        end else begin
            prev_frame_q <= tx_frame_i;
            mode_seen_q  <= mode_i;
            valid_q      <= 1'b0;
            // A mode change re-hunts silently; it is not a framing error.
            if (mode_i != mode_seen_q) begin
                state_q <= DF_HUNT;
            end else if (state_q == DF_HUNT) begin
                if (tx_frame_i && !prev_frame_q) begin
                    state_q  <= DF_LOCKED;
                    cap_i0_q <= tx_data_i;
                    rphase_q <= PH_Q0;
                end
            end else if (tx_frame_i != exp_frame) begin
                state_q <= DF_HUNT;
                if (err_q != '1) err_q <= err_q + 1'b1;
            end else begin
                case (rphase_q)
                    PH_I0:   cap_i0_q <= tx_data_i;
                    PH_Q0:   cap_q0_q <= tx_data_i;
                    PH_I1:   cap_i1_q <= tx_data_i;
                    default: ;
                endcase
                if (final_word) begin
                    // SISO ends on Q0, so the live word doubles as Q1.
                    snk_i0_q <= cap_i0_q;
                    snk_q0_q <= mode_i ? cap_q0_q : tx_data_i;
                    snk_i1_q <= mode_i ? cap_i1_q : cap_i0_q;
                    snk_q1_q <= tx_data_i;
                    valid_q  <= 1'b1;
                    rphase_q <= PH_I0;
                end else begin
                    rphase_q <= phase_e'(rphase_q + 2'd1);
                end
            end
        end
    end

    assign snk_i0_o        = snk_i0_q;
    assign snk_q0_o        = snk_q0_q;
    assign snk_i1_o        = snk_i1_q;
    assign snk_q1_o        = snk_q1_q;
    assign snk_valid_o     = valid_q;
    assign locked_o        = (state_q == DF_LOCKED);
    assign frame_err_cnt_o = err_q;

endmodule

// File: rtl/catalina_emu.sv
// AD9361 data-port emulator: serializes source sample sets onto the RX bus
// and hands the TX bus to the deframer.
module catalina_emu
    import catalina_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mimo,
    input  logic [WIDTH-1:0] src_i0,
    input  logic [WIDTH-1:0] src_q0,
    input  logic [WIDTH-1:0] src_i1,
    input  logic [WIDTH-1:0] src_q1,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             rx_frame,
    output logic [WIDTH-1:0] rx_data,
    input  logic             tx_frame,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] snk_i0,
    output logic [WIDTH-1:0] snk_q0,
    output logic [WIDTH-1:0] snk_i1,
    output logic [WIDTH-1:0] snk_q1,
    output logic             snk_valid,
    output logic             locked,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] underrun_cnt
);

    phase_e           phase_q, phase_d;
    logic             mode_q;
    logic [WIDTH-1:0] hold_q0_q, hold_i1_q, hold_q1_q;
    logic             rx_frame_q, rx_frame_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0] und_q;
    logic             last;

    assign last = (phase_q == last_phase(mode_q));

    // I0 of a newly accepted set goes straight to the bus; the rest is held.
    always_comb begin
        phase_d    = last ? PH_I0 : phase_e'(phase_q + 2'd1);
        rx_frame_d = frame_bit(last ? mimo : mode_q, phase_d);
        rx_data_d  = '0;
        if (last) begin
            if (src_valid) rx_data_d = src_i0;
        end else begin
            case (phase_d)
                PH_Q0:   rx_data_d = hold_q0_q;
                PH_I1:   rx_data_d = hold_i1_q;
                PH_Q1:   rx_data_d = hold_q1_q;
                default: rx_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= PH_Q0;
            mode_q     <= 1'b0;
            hold_q0_q  <= '0;
            hold_i1_q  <= '0;
            hold_q1_q  <= '0;
            rx_frame_q <= 1'b0;
            rx_data_q  <= '0;
            und_q      <= '0;
        end else begin
            phase_q    <= phase_d;
            rx_frame_q <= rx_frame_d;
            rx_data_q  <= rx_data_d;
            if (last) begin
                mode_q <= mimo;
                if (src_valid) begin
                    hold_q0_q <= src_q0;
                    hold_i1_q <= src_i1;
                    hold_q1_q <= src_q1;
                end else begin
                    hold_q0_q <= '0;
                    hold_i1_q <= '0;
                    hold_q1_q <= '0;
                    if (und_q != '1) und_q <= und_q + 1'b1;
                end
            end
        end
    end

    assign src_ready    = last;
    assign rx_frame     = rx_frame_q;
    assign rx_data      = rx_data_q;
    assign underrun_cnt = und_q;

    catalina_deframer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_deframer (
        .clk            (clk),
        .reset          (reset),
        .mode_i         (mode_q),
        .tx_frame_i     (tx_frame),
        .tx_data_i      (tx_data),
        .snk_i0_o       (snk_i0),
        .snk_q0_o       (snk_q0),
        .snk_i1_o       (snk_i1),
        .snk_q1_o       (snk_q1),
        .snk_valid_o    (snk_valid),
        .locked_o       (locked),
        .frame_err_cnt_o(frame_err_cnt)
    );

endmodule

// File: tb/tb_catalina_emu.sv
// Directed bench for catalina_emu: TX serialization, deframing, errors,
// underruns, mode switching and reset behaviour.
module tb_catalina_emu;

    localparam int W  = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, mimo, src_valid, src_ready;
    logic [W-1:0]  src_i0, src_q0, src_i1, src_q1;
    logic          rx_frame, tx_frame, snk_valid, locked;
    logic [W-1:0]  rx_data, tx_data, snk_i0, snk_q0, snk_i1, snk_q1;
    logic [CW-1:0] frame_err_cnt, underrun_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    catalina_emu #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mimo         (mimo),
        .src_i0       (src_i0),
        .src_q0       (src_q0),
        .src_i1       (src_i1),
        .src_q1       (src_q1),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .rx_frame     (rx_frame),
        .rx_data      (rx_data),
        .tx_frame     (tx_frame),
        .tx_data      (tx_data),
        .snk_i0       (snk_i0),
        .snk_q0       (snk_q0),
        .snk_i1       (snk_i1),
        .snk_q1       (snk_q1),
        .snk_valid    (snk_valid),
        .locked       (locked),
        .frame_err_cnt(frame_err_cnt),
        .underrun_cnt (underrun_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mimo = 1'b0; src_valid = 1'b0;
        src_i0 = '0; src_q0 = '0; src_i1 = '0; src_q1 = '0;
        tx_frame = 1'b0; tx_data = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({src_ready, rx_frame, rx_data, snk_valid, locked} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b fr=%b d=%h v=%b lk=%b want 1 0 000 0 0",
                     src_ready, rx_frame, rx_data, snk_valid, locked);
        end
        checks++;
        if ({snk_i0, snk_q0, snk_i1, snk_q1, frame_err_cnt, underrun_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got snk=%h %h %h %h err=%0d und=%0d want all zero",
                     snk_i0, snk_q0, snk_i1, snk_q1, frame_err_cnt, underrun_cnt);
        end
        // previous-frame bit resets to 1, so a high frame right away is not an edge
        tx_frame = 1'b1;
        step();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_prev_frame: got locked=%b want 0", locked);
        end
    endtask

    task automatic test_siso();
        logic [W-1:0] exp_d [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
        logic         exp_f [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic         exp_r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        src_i0 = 12'h123; src_q0 = 12'h456; src_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) begin src_i0 = 12'h789; src_q0 = 12'hABC; end
            checks++;
            if ({rx_data, rx_frame, src_ready} !== {exp_d[i], exp_f[i], exp_r[i]}) begin
                errors++;
                $display("FAIL siso_word%0d: got d=%h fr=%b rdy=%b want d=%h fr=%b rdy=%b",
                         i, rx_data, rx_frame, src_ready, exp_d[i], exp_f[i], exp_r[i]);
            end
        end
        checks++;
        if (underrun_cnt !== 4'd0) begin
            errors++;
            $display("FAIL siso_underrun: got %0d want 0", underrun_cnt);
        end
    endtask

    task automatic test_mimo();
        logic [W-1:0] exp_d [4] = '{12'h001, 12'h002, 12'h003, 12'h004};
        logic         exp_f [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        mimo = 1'b1; src_valid = 1'b1;
        src_i0 = 12'h001; src_q0 = 12'h002; src_i1 = 12'h003; src_q1 = 12'h004;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({rx_data, rx_frame} !== {exp_d[i], exp_f[i]}) begin
                errors++;
                $display("FAIL mimo_word%0d: got d=%h fr=%b want d=%h fr=%b",
                         i, rx_data, rx_frame, exp_d[i], exp_f[i]);
            end
        end
    endtask

    // Lock in MIMO, deliver one set, then corrupt phase 2 and re-lock.
    task automatic test_deframer();
        logic [W-1:0] td [14] = '{12'h000, 12'h00A, 12'h00B, 12'h00C, 12'h00D, 12'h00E, 12'h00F,
                                  12'h010, 12'h011, 12'h012, 12'h013, 12'h014, 12'h015, 12'h000};
        logic         tf [14] = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0};
        logic         exp_lk [15] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
        logic         exp_v  [15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        do_reset();
        mimo = 1'b1; src_valid = 1'b1;
        tx_frame = 1'b0; tx_data = '0;
        for (int m = 1; m <= 14; m++) begin
            step();
            checks++;
            if ({locked, snk_valid, frame_err_cnt} !== {exp_lk[m], exp_v[m], (m >= 9) ? 4'd1 : 4'd0}) begin
                errors++;
                $display("FAIL dfr_cycle%0d: got lk=%b v=%b err=%0d want lk=%b v=%b err=%0d",
                         m, locked, snk_valid, frame_err_cnt, exp_lk[m], exp_v[m], (m >= 9) ? 1 : 0);
            end
            if (m == 6 || m == 10) begin
                checks++;
                if ({snk_i0, snk_q0, snk_i1, snk_q1} !== {12'h00A, 12'h00B, 12'h00C, 12'h00D}) begin
                    errors++;
                    $display("FAIL dfr_set1_c%0d: got %h %h %h %h want 00a 00b 00c 00d",
                             m, snk_i0, snk_q0, snk_i1, snk_q1);
                end
            end
            if (m == 14) begin
                checks++;
                if ({snk_i0, snk_q0, snk_i1, snk_q1} !== {12'h012, 12'h013, 12'h014, 12'h015}) begin
                    errors++;
                    $display("FAIL dfr_set2: got %h %h %h %h want 012 013 014 015",
                             snk_i0, snk_q0, snk_i1, snk_q1);
                end
            end
            tx_frame = tf[m-1];
            tx_data  = td[m-1];
        end
    endtask

    // RX looped back to TX; mimo drops mid-period in the second MIMO period.
    task automatic test_mode_switch();
        logic exp_f  [14] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
        logic exp_lk [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
        logic exp_v  [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        do_reset();
        mimo = 1'b1; src_valid = 1'b1;
        src_i0 = 12'h001; src_q0 = 12'h002; src_i1 = 12'h003; src_q1 = 12'h004;
        tx_frame = rx_frame; tx_data = rx_data;
        for (int m = 1; m <= 13; m++) begin
            step();
            checks++;
            if ({rx_frame, locked, snk_valid, frame_err_cnt} !== {exp_f[m], exp_lk[m], exp_v[m], 4'd0}) begin
                errors++;
                $display("FAIL mode_cycle%0d: got fr=%b lk=%b v=%b err=%0d want fr=%b lk=%b v=%b err=0",
                         m, rx_frame, locked, snk_valid, frame_err_cnt, exp_f[m], exp_lk[m], exp_v[m]);
            end
            if (m == 9) begin
                checks++;
                if ({snk_i0, snk_q0, snk_i1, snk_q1} !== {12'h001, 12'h002, 12'h003, 12'h004}) begin
                    errors++;
                    $display("FAIL mode_mimo_set: got %h %h %h %h want 001 002 003 004",
                             snk_i0, snk_q0, snk_i1, snk_q1);
                end
            end
            if (m == 13) begin
                checks++;
                if ({snk_i0, snk_q0, snk_i1, snk_q1} !== {12'h001, 12'h002, 12'h001, 12'h002}) begin
                    errors++;
                    $display("FAIL mode_siso_set: got %h %h %h %h want 001 002 001 002",
                             snk_i0, snk_q0, snk_i1, snk_q1);
                end
            end
            if (m == 6) mimo = 1'b0;
            tx_frame = rx_frame;
            tx_data  = rx_data;
        end
    endtask

    task automatic test_underrun();
        logic exp_f [6] = '{1, 0, 1, 0, 1, 0};
        int   exp_u [6] = '{1, 1, 2, 2, 3, 3};
        do_reset();
        for (int m = 0; m < 6; m++) begin
            step();
            checks++;
            if ({rx_data, rx_frame} !== {12'h000, exp_f[m]} || underrun_cnt !== exp_u[m][CW-1:0]) begin
                errors++;
                $display("FAIL underrun_c%0d: got d=%h fr=%b und=%0d want d=000 fr=%b und=%0d",
                         m + 1, rx_data, rx_frame, underrun_cnt, exp_f[m], exp_u[m]);
            end
        end
        src_valid = 1'b1; src_i0 = 12'h111; src_q0 = 12'h222;
        step();
        checks++;
        if ({rx_data, rx_frame, underrun_cnt} !== {12'h111, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL underrun_resume: got d=%h fr=%b und=%0d want d=111 fr=1 und=3",
                     rx_data, rx_frame, underrun_cnt);
        end
        src_valid = 1'b0;
        for (int m = 0; m < 40; m++) step();
        checks++;
        if (underrun_cnt !== 4'hF) begin
            errors++;
            $display("FAIL underrun_saturate: got %0d want 15", underrun_cnt);
        end
    endtask

    task automatic test_reset_midperiod();
        do_reset();
        tx_frame = rx_frame; tx_data = rx_data;
        step();
        tx_frame = rx_frame; tx_data = rx_data;
        step();
        checks++;
        if ({locked, underrun_cnt} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL midreset_pre: got lk=%b und=%0d want lk=1 und=1", locked, underrun_cnt);
        end
        tx_frame = rx_frame; tx_data = rx_data;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({snk_valid, locked, rx_frame, underrun_cnt, frame_err_cnt} !== {1'b0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL midreset_post: got v=%b lk=%b fr=%b und=%0d err=%0d want 0 0 0 0 0",
                     snk_valid, locked, rx_frame, underrun_cnt, frame_err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_siso();
        test_mimo();
        test_deframer();
        test_mode_switch();
        test_underrun();
        test_reset_midperiod();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
